// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 set-2 definitions: scan codes, game-key indices and tracker FSM states.
package ps2_keys_pkg;

    // Number of tracked game keys and width of a key index
    localparam int NUM_KEYS = 17;
    localparam int IDX_W    = 5;

    typedef logic [IDX_W-1:0] key_idx_t;

    // Prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    // Extended (E0-prefixed) arrow codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Plain codes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_Y     = 8'h35;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_L     = 8'h4B;
    localparam logic [7:0] SC_SEMI  = 8'h4C;
    localparam logic [7:0] SC_QUOTE = 8'h52;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // Key indices into the held bitmap
    localparam key_idx_t K_UP    = 5'd0;
    localparam key_idx_t K_DOWN  = 5'd1;
    localparam key_idx_t K_LEFT  = 5'd2;
    localparam key_idx_t K_RIGHT = 5'd3;
    localparam key_idx_t K_W     = 5'd4;
    localparam key_idx_t K_A     = 5'd5;
    localparam key_idx_t K_S     = 5'd6;
    localparam key_idx_t K_D     = 5'd7;
    localparam key_idx_t K_Y     = 5'd8;
    localparam key_idx_t K_G     = 5'd9;
    localparam key_idx_t K_H     = 5'd10;
    localparam key_idx_t K_J     = 5'd11;
    localparam key_idx_t K_P     = 5'd12;
    localparam key_idx_t K_L     = 5'd13;
    localparam key_idx_t K_SEMI  = 5'd14;
    localparam key_idx_t K_QUOTE = 5'd15;
    localparam key_idx_t K_SPACE = 5'd16;

    // Prefix-protocol state: which prefix bytes have been seen
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/ps2_code_lookup.sv
// Combinational map from (scan code, extended flag) to game-key index.
module ps2_code_lookup
    import ps2_keys_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic       i_ext,
    output logic       o_hit,
    output key_idx_t   o_idx
);

    // Arrows only match with the E0 prefix; letters and space only without it
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_hit = 1'b1;
        o_idx = '0;
        if (i_ext) begin
            case (i_code)
                SC_UP:    o_idx = K_UP;
                SC_DOWN:  o_idx = K_DOWN;
                SC_LEFT:  o_idx = K_LEFT;
                SC_RIGHT: o_idx = K_RIGHT;
                default:  o_hit = 1'b0;
            endcase
        end else begin
            case (i_code)
                SC_W:     o_idx = K_W;
                SC_A:     o_idx = K_A;
                SC_S:     o_idx = K_S;
                SC_D:     o_idx = K_D;
                SC_Y:     o_idx = K_Y;
                SC_G:     o_idx = K_G;
                SC_H:     o_idx = K_H;
                SC_J:     o_idx = K_J;
                SC_P:     o_idx = K_P;
                SC_L:     o_idx = K_L;
                SC_SEMI:  o_idx = K_SEMI;
                SC_QUOTE: o_idx = K_QUOTE;
                SC_SPACE: o_idx = K_SPACE;
                default:  o_hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Runs the set-2 E0/F0 prefix protocol over received bytes, keeps the held-key
// bitmap and emits one event per real press or release (repeats suppressed).
module ps2_key_tracker
    import ps2_keys_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int TO_W        = 18
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                code_valid,
    input  logic [7:0]          code_byte,
    input  logic                code_err,
    input  logic                flush,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                key_event,
    output key_idx_t            key_event_idx,
    output logic                key_event_make,
    output logic                proto_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    fsm_state_t          r_state;
    fsm_state_t          w_next_state;
    logic [TO_W-1:0]     r_to_cnt;
    logic [NUM_KEYS-1:0] r_key_held;
    logic                r_key_event;
    key_idx_t            r_key_event_idx;
    logic                r_key_event_make;
    logic                r_proto_err;

    logic     w_in_prefix;
    logic     w_expire;
    logic     w_take;
    logic     w_ext;
    logic     w_do_key;
    logic     w_make;
    logic     w_hit;
    key_idx_t w_idx;
    logic     w_proto_err;

    assign w_in_prefix = (r_state != ST_IDLE);
    assign w_ext       = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
    // A valid byte in the expiry cycle wins over the timeout
    assign w_expire    = w_in_prefix && (r_to_cnt == TO_LAST) && !code_valid;
    assign w_take      = code_valid && !code_err && !flush;
    assign w_proto_err = !flush && ((code_valid && code_err) || w_expire);

    ps2_code_lookup u_lookup (
        .i_code (code_byte),
        .i_ext  (w_ext),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state: flush, then error byte, then valid byte, then timeout
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else if (code_valid) begin
            if (code_err) begin
                w_next_state = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE, ST_EXT: begin
                        if (code_byte == SC_E0)      w_next_state = ST_EXT;
                        else if (code_byte == SC_F0) w_next_state = w_ext ? ST_EXT_BRK : ST_BRK;
                        else                         w_next_state = ST_IDLE;
                    end
                    default: w_next_state = ST_IDLE;
                endcase
            end
        end else if (w_expire) begin
            w_next_state = ST_IDLE;
        end
    end

    // FSM outputs: decide whether this byte is a make or a break of a key code
    always_comb begin
        w_do_key = 1'b0;
        w_make   = 1'b0;
        if (w_take) begin
            case (r_state)
                ST_IDLE, ST_EXT: begin
                    if (code_byte != SC_E0 && code_byte != SC_F0) begin
                        w_do_key = 1'b1;
                        w_make   = 1'b1;
                    end
                end
                default: w_do_key = 1'b1;
            endcase
        end
    end

    // Prefix timeout counter: only runs while waiting inside a prefix
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if (flush || code_valid || !w_in_prefix || w_expire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Held bitmap and event register; only real transitions produce an event
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_key_held       <= '0;
            r_key_event      <= 1'b0;
            r_key_event_idx  <= '0;
            r_key_event_make <= 1'b0;
            r_proto_err      <= 1'b0;
        end else begin
            r_key_event <= 1'b0;
            r_proto_err <= w_proto_err;
            if (flush) begin
                r_key_held <= '0;
            end else if (w_do_key && w_hit && (r_key_held[w_idx] != w_make)) begin
                r_key_held[w_idx] <= w_make;
                r_key_event       <= 1'b1;
                r_key_event_idx   <= w_idx;
                r_key_event_make  <= w_make;
            end
        end
    end

    assign key_held       = r_key_held;
    assign key_event      = r_key_event;
    assign key_event_idx  = r_key_event_idx;
    assign key_event_make = r_key_event_make;
    assign proto_err      = r_proto_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a shortened prefix timeout.
module tb_ps2_key_tracker;

    localparam int TO_CYC = 20;

    logic        clk;
    logic        resetn;
    logic        code_valid;
    logic [7:0]  code_byte;
    logic        code_err;
    logic        flush;
    logic [16:0] key_held;
    logic        key_event;
    logic [4:0]  key_event_idx;
    logic        key_event_make;
    logic        proto_err;

    int n_vec;
    int n_bad;

    // Expected output state
    logic [16:0] e_held;
    logic        e_ev;
    logic [4:0]  e_idx;
    logic        e_make;
    logic        e_perr;

    ps2_key_tracker #(.TIMEOUT_CYC(TO_CYC), .TO_W(5)) dut (
        .CLOCK_50       (clk),
        .resetn         (resetn),
        .code_valid     (code_valid),
        .code_byte      (code_byte),
        .code_err       (code_err),
        .flush          (flush),
        .key_held       (key_held),
        .key_event      (key_event),
        .key_event_idx  (key_event_idx),
        .key_event_make (key_event_make),
        .proto_err      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] obs_vec();
        return {key_held, key_event, key_event_idx, key_event_make, proto_err};
    endfunction

    function automatic logic [24:0] exp_vec();
        return {e_held, e_ev, e_idx, e_make, e_perr};
    endfunction

    // Drive inputs for one cycle, then sample just after the rising edge
    task automatic step(input logic v, input logic [7:0] b, input logic err, input logic fl);
        @(negedge clk);
        code_valid = v;
        code_byte  = b;
        code_err   = err;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Expectation helpers: no event / event this cycle
    task automatic exp_none();
        e_ev = 1'b0; e_perr = 1'b0;
    endtask

    task automatic exp_event(input logic [4:0] idx, input logic mk);
        e_ev = 1'b1; e_idx = idx; e_make = mk; e_perr = 1'b0;
        if (mk) e_held[idx] = 1'b1;
        else    e_held[idx] = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; code_valid = 1'b0; code_byte = 8'h00; code_err = 1'b0; flush = 1'b0;
        e_held = '0; e_ev = 0; e_idx = '0; e_make = 0; e_perr = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL reset: got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_make_repeat();
        step(1'b1, 8'h1D, 1'b0, 1'b0); exp_event(5'd4, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL make_W: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'h1D, 1'b0, 1'b0); exp_none();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL repeat_W: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_ext();
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        step(1'b1, 8'h75, 1'b0, 1'b0); exp_event(5'd0, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL make_up: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'hE0, 1'b0, 1'b0); exp_none();
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL prefix_quiet: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'h75, 1'b0, 1'b0); exp_event(5'd0, 1'b0);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL break_up: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'h75, 1'b0, 1'b0); exp_none();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL bare_75: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 8'h00, 1'b0, 1'b1); e_held = '0; exp_none();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL flush_clear: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'h1C, 1'b0, 1'b0); exp_event(5'd5, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL b2b_first: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'h29, 1'b0, 1'b0); exp_event(5'd16, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec() || key_held !== 17'h10020) begin
            n_bad++; $display("FAIL b2b_second: got %h want %h", obs_vec(), exp_vec());
        end
        idle(); exp_none();
    endtask

    task automatic test_timeout();
        int k;
        step(1'b1, 8'hF0, 1'b0, 1'b0); exp_none();
        k = -1;
        for (int i = 1; i <= TO_CYC + 5; i++) begin
            idle();
            if (proto_err === 1'b1 && k < 0) k = i;
        end
        n_vec++;
        if (k !== TO_CYC) begin
            n_bad++; $display("FAIL timeout_cycle: got %0d want %0d", k, TO_CYC);
        end
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL timeout_pulse_end: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'h1B, 1'b0, 1'b0); exp_event(5'd6, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL post_timeout_make: got %h want %h", obs_vec(), exp_vec());
        end
        // Byte landing in the expiry cycle is still a break
        step(1'b1, 8'hF0, 1'b0, 1'b0); exp_none();
        for (int i = 1; i < TO_CYC; i++) idle();
        step(1'b1, 8'h1B, 1'b0, 1'b0); exp_event(5'd6, 1'b0);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL expiry_byte_wins: got %h want %h", obs_vec(), exp_vec());
        end
        idle(); exp_none();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL expiry_no_err: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_err_flush();
        step(1'b0, 8'h00, 1'b0, 1'b1); e_held = '0; exp_none();
        step(1'b1, 8'h1D, 1'b0, 1'b0); exp_event(5'd4, 1'b1);
        step(1'b1, 8'h1C, 1'b0, 1'b0); exp_event(5'd5, 1'b1);
        step(1'b1, 8'h1B, 1'b0, 1'b0); exp_event(5'd6, 1'b1);
        step(1'b1, 8'h23, 1'b0, 1'b0); exp_event(5'd7, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec() || key_held !== 17'h000F0) begin
            n_bad++; $display("FAIL hold_4_7: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'hF0, 1'b1, 1'b0); exp_none(); e_perr = 1'b1;
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL err_byte: got %h want %h", obs_vec(), exp_vec());
        end
        // FSM back in IDLE: 1D is a make repeat, not a break
        step(1'b1, 8'h1D, 1'b0, 1'b0); exp_none();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL err_to_idle: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'h29, 1'b0, 1'b1); e_held = '0; exp_none();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL flush_beats_valid: got %h want %h", obs_vec(), exp_vec());
        end
        idle();
    endtask

    task automatic test_async_reset();
        step(1'b1, 8'h1D, 1'b0, 1'b0); exp_event(5'd4, 1'b1);
        step(1'b1, 8'hE0, 1'b0, 1'b0); exp_none();
        @(negedge clk);
        code_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        e_held = '0; e_ev = 0; e_idx = '0; e_make = 0; e_perr = 0;
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 8'h72, 1'b0, 1'b0); exp_none();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL plain_72_miss: got %h want %h", obs_vec(), exp_vec());
        end
        step(1'b1, 8'h29, 1'b0, 1'b0); exp_event(5'd16, 1'b1);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL post_reset_make: got %h want %h", obs_vec(), exp_vec());
        end
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_make_repeat();
        test_ext();
        test_back_to_back();
        test_timeout();
        test_err_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
